// File: rtl/alu_mul_sequencer.sv
// Shift-add unsigned multiplier that borrows the shared ALU for its ADD and SLL steps,
// one ALU operation per cycle; returns the low DATA_W bits of a*b.
module alu_mul_sequencer #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ITER   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic [DATA_W-1:0] multiplicand_i,
   input  logic [DATA_W-1:0] multiplier_i,
   input  logic [DATA_W-1:0] alu_data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] product_o,
   output logic              alu_sel_o,
   output logic [3:0]        alu_operation_o,
   output logic [DATA_W-1:0] alu_a_o,
   output logic [DATA_W-1:0] alu_b_o,
   output logic [4:0]        alu_shamt_o
);

   localparam int unsigned       CNT_W     = $clog2(ITER + 1);
   localparam logic [DATA_W-1:0] ITER_MASK = {DATA_W{1'b1}} >> (DATA_W - ITER);
   localparam logic [3:0]        OP_ADD    = 4'b0011;
   localparam logic [3:0]        OP_SLL    = 4'b0010;

   typedef enum logic [2:0] {IDLE, EVAL, ADD, SHIFT, DONE} state_t;

   state_t            state, state_nx;
   logic [DATA_W-1:0] acc, mcand, mplier, product_q;
   logic [CNT_W-1:0]  cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         cnt       <= '0;
         product_q <= '0;
      end else begin
         state <= state_nx;
         unique case (state)
            IDLE: begin
               if (start_i) begin
                  mcand  <= multiplicand_i;
                  // Bits above ITER never contribute, so dropping them here lets the
                  // loop end at the highest useful bit instead of running all ITER steps.
                  mplier <= multiplier_i & ITER_MASK;
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            ADD:   acc <= alu_data_i;
            SHIFT: begin
               mcand  <= alu_data_i;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
            end
            DONE:  product_q <= acc;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx        = state;
      busy_o          = 1'b1;
      done_o          = 1'b0;
      product_o       = product_q;
      alu_sel_o       = 1'b0;
      alu_operation_o = '0;
      alu_a_o         = '0;
      alu_b_o         = '0;
      alu_shamt_o     = '0;
      unique case (state)
         IDLE: begin
            busy_o = 1'b0;
            if (start_i) state_nx = EVAL;
         end
         EVAL: begin
            if (mplier == '0 || cnt == CNT_W'(ITER)) state_nx = DONE;
            else if (mplier[0])                      state_nx = ADD;
            else                                     state_nx = SHIFT;
         end
         ADD: begin
            alu_sel_o       = 1'b1;
            alu_operation_o = OP_ADD;
            alu_a_o         = acc;
            alu_b_o         = mcand;
            state_nx        = SHIFT;
         end
         SHIFT: begin
            alu_sel_o       = 1'b1;
            alu_operation_o = OP_SLL;
            alu_b_o         = mcand;
            alu_shamt_o     = 5'd1;
            state_nx        = EVAL;
         end
         DONE: begin
            done_o    = 1'b1;
            product_o = acc;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: two instances (ITER=32 and ITER=4) driven by directed and
// random multiplies, each checked every cycle against a per-cycle schedule built from a*b.
module tb_alu_mul_sequencer;
   localparam int W = 32;

   typedef struct {
      logic         busy;
      logic         done;
      logic         sel;
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [4:0]   shamt;
      logic [W-1:0] prod;
   } rec_t;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         st [2];
   logic [W-1:0] ma [2], mb [2], alu_d [2], prod [2], aa [2], ab [2];
   logic         busy [2], done [2], sel [2];
   logic [3:0]   op [2];
   logic [4:0]   sh [2];

   int vectors = 0, miscompares = 0;
   int iters [2] = '{32, 4};

   rec_t         cur [2];
   rec_t         sched [2][$];
   logic [W-1:0] held [2];

   always #5 clk = ~clk;

   alu_mul_sequencer #(.DATA_W(W), .ITER(32)) dut0 (
      .clk(clk), .reset(reset), .start_i(st[0]), .multiplicand_i(ma[0]), .multiplier_i(mb[0]),
      .alu_data_i(alu_d[0]), .busy_o(busy[0]), .done_o(done[0]), .product_o(prod[0]),
      .alu_sel_o(sel[0]), .alu_operation_o(op[0]), .alu_a_o(aa[0]), .alu_b_o(ab[0]),
      .alu_shamt_o(sh[0]));

   alu_mul_sequencer #(.DATA_W(W), .ITER(4)) dut1 (
      .clk(clk), .reset(reset), .start_i(st[1]), .multiplicand_i(ma[1]), .multiplier_i(mb[1]),
      .alu_data_i(alu_d[1]), .busy_o(busy[1]), .done_o(done[1]), .product_o(prod[1]),
      .alu_sel_o(sel[1]), .alu_operation_o(op[1]), .alu_a_o(aa[1]), .alu_b_o(ab[1]),
      .alu_shamt_o(sh[1]));

   // Shared ALU stand-in
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         alu_d[i] = '0;
         if (op[i] == 4'b0011)      alu_d[i] = aa[i] + ab[i];
         else if (op[i] == 4'b0010) alu_d[i] = ab[i] << sh[i];
      end
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic rec_t idle_rec(input logic [W-1:0] p);
      rec_t r = '{default: 0};
      r.prod = p;
      return r;
   endfunction

   function automatic rec_t busy_rec(input int n);
      rec_t r = idle_rec(held[n]);
      r.busy = 1'b1;
      return r;
   endfunction

   // Per-cycle expectations for one multiply, one entry per cycle after the accepting edge
   task automatic build(input int n, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] bm, acc;
      int           top;
      rec_t         r;
      bm  = (iters[n] >= W) ? b : (b & ((W'(1) << iters[n]) - W'(1)));
      top = -1;
      acc = '0;
      for (int i = 0; i < W; i++) if (bm[i]) top = i;
      for (int i = 0; i <= top; i++) begin
         r = busy_rec(n);
         sched[n].push_back(r);
         if (bm[i]) begin
            r.sel = 1'b1; r.op = 4'b0011; r.a = acc; r.b = a << i;
            sched[n].push_back(r);
            acc += a << i;
         end
         r = busy_rec(n);
         r.sel = 1'b1; r.op = 4'b0010; r.b = a << i; r.shamt = 5'd1;
         sched[n].push_back(r);
      end
      r = busy_rec(n);
      sched[n].push_back(r);
      r.done = 1'b1;
      r.prod = a * bm;
      sched[n].push_back(r);
   endtask

   always @(posedge clk) begin
      if (reset) begin
         for (int n = 0; n < 2; n++) begin
            if (!cur[n].busy && st[n]) build(n, ma[n], mb[n]);
            if (sched[n].size() > 0) cur[n] = sched[n].pop_front();
            else                     cur[n] = idle_rec(held[n]);
            if (cur[n].done) held[n] = cur[n].prod;
         end
      end
   end

   always @(negedge reset) begin
      for (int n = 0; n < 2; n++) begin
         sched[n].delete();
         held[n] = '0;
         cur[n]  = idle_rec('0);
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         for (int n = 0; n < 2; n++) begin
            chk($sformatf("u%0d busy", n),  W'(busy[n]), W'(cur[n].busy));
            chk($sformatf("u%0d done", n),  W'(done[n]), W'(cur[n].done));
            chk($sformatf("u%0d sel", n),   W'(sel[n]),  W'(cur[n].sel));
            chk($sformatf("u%0d op", n),    W'(op[n]),   W'(cur[n].op));
            chk($sformatf("u%0d alu_a", n), aa[n],       cur[n].a);
            chk($sformatf("u%0d alu_b", n), ab[n],       cur[n].b);
            chk($sformatf("u%0d shamt", n), W'(sh[n]),   W'(cur[n].shamt));
            chk($sformatf("u%0d prod", n),  prod[n],     cur[n].prod);
         end
      end
   end

   task automatic go(input int n, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      st[n] = 1'b1; ma[n] = a; mb[n] = b;
      @(negedge clk);
      st[n] = 1'b0; ma[n] = $urandom; mb[n] = $urandom;
   endtask

   task automatic run(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input bit noise,
                      output logic [W-1:0] p, output int lat);
      go(n, a, b);
      lat = 1;
      while (!done[n] && lat < 300) begin
         if (noise) begin
            st[n] = 1'($urandom_range(0, 1)); ma[n] = $urandom; mb[n] = $urandom;
         end
         @(negedge clk);
         lat++;
      end
      vectors++;
      if (!done[n]) begin
         miscompares++;
         $display("FAIL u%0d done timeout: no done_o within %0d cycles", n, lat);
      end
      p     = prod[n];
      st[n] = 1'b0;
   endtask

   initial begin
      logic [W-1:0] p;
      int           lat, dones;
      for (int n = 0; n < 2; n++) begin
         st[n] = 1'b0; ma[n] = '0; mb[n] = '0;
         held[n] = '0; cur[n] = idle_rec('0);
      end
      repeat (3) @(negedge clk);
      chk("reset busy", W'(busy[0]), '0);
      chk("reset prod", prod[0], '0);
      reset = 1'b1;

      run(0, 3, 5, 0, p, lat);
      chk("3*5 latency", W'(lat), 10);
      chk("3*5 product", p, 15);
      run(0, 32'h1234, 0, 0, p, lat);
      chk("b=0 latency", W'(lat), 2);
      chk("b=0 product", p, 0);
      run(0, 32'hFFFF_FFFF, 2, 0, p, lat);
      chk("wrap product", p, 32'hFFFF_FFFE);
      run(0, 32'h8000_0000, 32'h8000_0000, 0, p, lat);
      chk("msb latency", W'(lat), 67);
      chk("msb product", p, 0);

      // start pulse while busy must be ignored
      dones = 0;
      go(0, 3, 5);
      for (int c = 1; c <= 40; c++) begin
         if (done[0]) begin dones++; p = prod[0]; end
         if (c == 3) begin st[0] = 1'b1; ma[0] = 7; mb[0] = 9; end
         if (c == 4) st[0] = 1'b0;
         @(negedge clk);
      end
      chk("ignored start dones", W'(dones), 1);
      chk("ignored start product", p, 15);

      // asynchronous reset in the middle of an operation
      go(0, 3, 5);
      repeat (3) @(negedge clk);
      #1 reset = 1'b0;
      #1;
      chk("abort busy", W'(busy[0]), '0);
      chk("abort done", W'(done[0]), '0);
      chk("abort sel", W'(sel[0]), '0);
      chk("abort op", W'(op[0]), '0);
      chk("abort alu_b", ab[0], '0);
      chk("abort shamt", W'(sh[0]), '0);
      chk("abort prod", prod[0], '0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      run(0, 6, 7, 0, p, lat);
      chk("6*7 latency", W'(lat), 11);
      chk("6*7 product", p, 42);

      run(1, 1, 32'h13, 0, p, lat);
      chk("iter4 latency", W'(lat), 8);
      chk("iter4 product", p, 3);
      run(1, 5, 6, 0, p, lat);
      chk("back-to-back latency", W'(lat), 10);
      chk("back-to-back product", p, 30);

      for (int t = 0; t < 60; t++) begin
         logic [W-1:0] ra, rb;
         int           n;
         n  = int'($urandom_range(0, 1));
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         run(n, ra, rb, 1, p, lat);
      end
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
